// File: rtl/mcpu_pkg.sv
// ----------------------------------------------------------------------------
// mcpu_pkg
// Shared definitions for the MCPU datapath: the opcode width and the opcode
// encodings understood by the ALU.
// Ports: none (package).
// ----------------------------------------------------------------------------
package mcpu_pkg;

    localparam int CMD_SIZE = 2;

    localparam logic [CMD_SIZE-1:0] OP_AND = 2'b00;
    localparam logic [CMD_SIZE-1:0] OP_OR  = 2'b01;
    localparam logic [CMD_SIZE-1:0] OP_XOR = 2'b10;
    localparam logic [CMD_SIZE-1:0] OP_ADD = 2'b11;

endpackage

// File: rtl/mcpu_alu_core.sv
// ----------------------------------------------------------------------------
// mcpu_alu_core
// Purely combinational heart of the MCPU ALU. Decodes the opcode and produces
// the low half of the next result together with the carry flag; the owning
// wrapper registers both.
// Ports:
//   i_opcode  [CMD_SIZE-1:0]   operation select (AND / OR / XOR / ADD)
//   i_r1      [WORD_SIZE-1:0]  operand A (unsigned)
//   i_r2      [WORD_SIZE-1:0]  operand B (unsigned)
//   o_result  [WORD_SIZE-1:0]  next low-half result
//   o_carry                    next carry flag, only ever set by ADD
// ----------------------------------------------------------------------------
module mcpu_alu_core
    import mcpu_pkg::*;
#(
    parameter int CMD_SIZE  = mcpu_pkg::CMD_SIZE,
    parameter int WORD_SIZE = 8
) (
    input  logic [CMD_SIZE-1:0]  i_opcode,
    input  logic [WORD_SIZE-1:0] i_r1,
    input  logic [WORD_SIZE-1:0] i_r2,
    output logic [WORD_SIZE-1:0] o_result,
    output logic                 o_carry
);

    logic [WORD_SIZE:0] w_sum;

    // The adder is one bit wider than the operands so the carry-out of an
    // unsigned add falls out as the top bit of the sum.
    assign w_sum = {1'b0, i_r1} + {1'b0, i_r2};

    // Full four-way decode. The carry defaults low so that only ADD can ever
    // raise it, and every path assigns both outputs so no latch is inferred
    // even when the opcode is unknown.
    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_opcode)
            OP_AND: o_result = i_r1 & i_r2;
            OP_OR:  o_result = i_r1 | i_r2;
            OP_XOR: o_result = i_r1 ^ i_r2;
            OP_ADD: begin
                o_result = w_sum[WORD_SIZE-1:0];
                o_carry  = w_sum[WORD_SIZE];
            end
            default: begin
                o_result = '0;
                o_carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mcpu_alu.sv
// ----------------------------------------------------------------------------
// mcpu_alu
// Registered four-operation ALU sitting between the register file read ports
// and the writeback path. Inputs are taken every cycle and the result appears
// one clock later; there is no enable or handshake.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset (clears out and OVERFLOW)
//   opcode    [CMD_SIZE-1:0]     operation select
//   r1        [WORD_SIZE-1:0]    operand A
//   r2        [WORD_SIZE-1:0]    operand B
//   out       [2*WORD_SIZE-1:0]  registered result; upper half always zero
//   OVERFLOW                     registered carry-out of ADD
// ----------------------------------------------------------------------------
module mcpu_alu
    import mcpu_pkg::*;
#(
    parameter int CMD_SIZE  = mcpu_pkg::CMD_SIZE,
    parameter int WORD_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CMD_SIZE-1:0]    opcode,
    input  logic [WORD_SIZE-1:0]   r1,
    input  logic [WORD_SIZE-1:0]   r2,
    output logic [2*WORD_SIZE-1:0] out,
    output logic                   OVERFLOW
);

    logic [WORD_SIZE-1:0]   w_result;
    logic                   w_carry;
    logic [2*WORD_SIZE-1:0] r_out;
    logic                   r_overflow;

    mcpu_alu_core #(
        .CMD_SIZE  (CMD_SIZE),
        .WORD_SIZE (WORD_SIZE)
    ) u_core (
        .i_opcode (opcode),
        .i_r1     (r1),
        .i_r2     (r2),
        .o_result (w_result),
        .o_carry  (w_carry)
    );

    // Output register. Reset wins over whatever operation is presented on the
    // same edge. The upper half is reserved for a future multiply, so it is
    // loaded with zeros for every operation today.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_out      <= {{WORD_SIZE{1'b0}}, w_result};
            r_overflow <= w_carry;
        end
    end

    assign out      = r_out;
    assign OVERFLOW = r_overflow;

endmodule

// File: tb/tb_mcpu_alu.sv
// ----------------------------------------------------------------------------
// tb_mcpu_alu
// Self-checking bench for mcpu_alu. Two instances are exercised side by side,
// one with 8-bit operands and one with 2-bit operands. Inputs change on the
// falling edge and results are compared on the following falling edge, which
// is exactly one rising edge later.
// ----------------------------------------------------------------------------
module tb_mcpu_alu;

    logic       clk;
    logic       reset;

    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] out8;
    logic        ov8;

    logic [1:0]  op2;
    logic [1:0]  a2;
    logic [1:0]  b2;
    logic [3:0]  out2;
    logic        ov2;

    int total;
    int bad;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expOut;
        logic        expOv;
    } vecT;

    vecT vecs[10];

    mcpu_alu #(.CMD_SIZE(2), .WORD_SIZE(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .opcode   (op8),
        .r1       (a8),
        .r2       (b8),
        .out      (out8),
        .OVERFLOW (ov8)
    );

    mcpu_alu #(.CMD_SIZE(2), .WORD_SIZE(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .opcode   (op2),
        .r1       (a2),
        .r2       (b2),
        .out      (out2),
        .OVERFLOW (ov2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour for a w-bit ALU, returned as {OVERFLOW, 16-bit out}.
    function automatic logic [16:0] model(input int w, input logic [1:0] op,
                                          input logic [7:0] a, input logic [7:0] b);
        logic [7:0] m;
        logic [8:0] s;
        logic [7:0] res;
        logic       ov;
        m   = 8'((1 << w) - 1);
        s   = {1'b0, a & m} + {1'b0, b & m};
        ov  = 1'b0;
        res = 8'h00;
        case (op)
            2'b00:   res = a & b & m;
            2'b01:   res = (a | b) & m;
            2'b10:   res = (a ^ b) & m;
            default: begin
                res = s[7:0] & m;
                ov  = s[w];
            end
        endcase
        return {ov, 8'h00, res};
    endfunction

    // Drive both instances; called just after a falling edge.
    task automatic applyStimulus(input logic rst,
                                 input logic [1:0] o8, input logic [7:0] x8, input logic [7:0] y8,
                                 input logic [1:0] o2, input logic [1:0] x2, input logic [1:0] y2);
        reset = rst;
        op8   = o8;
        a8    = x8;
        b8    = y8;
        op2   = o2;
        a2    = x2;
        b2    = y2;
    endtask

    // One comparison of {OVERFLOW, out} against the expected value.
    task automatic checkOutput(input string name, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got ov/out=%h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] got8();
        return {ov8, out8};
    endfunction

    function automatic logic [16:0] got2();
        return {ov2, 12'h000, out2};
    endfunction

    logic [16:0] exp8q;
    logic [16:0] exp2q;
    logic [1:0]  rop8;
    logic [1:0]  rop2;
    logic [7:0]  ra8;
    logic [7:0]  rb8;
    logic [1:0]  ra2;
    logic [1:0]  rb2;
    logic        rrst;

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{2'b00, 8'h04, 8'h04, 16'h0004, 1'b0};
        vecs[1] = '{2'b01, 8'h04, 8'h04, 16'h0004, 1'b0};
        vecs[2] = '{2'b10, 8'h04, 8'h04, 16'h0000, 1'b0};
        vecs[3] = '{2'b11, 8'h04, 8'h04, 16'h0008, 1'b0};
        vecs[4] = '{2'b11, 8'h08, 8'h08, 16'h0010, 1'b0};
        vecs[5] = '{2'b11, 8'hFF, 8'h01, 16'h0000, 1'b1};
        vecs[6] = '{2'b11, 8'h80, 8'h80, 16'h0000, 1'b1};
        vecs[7] = '{2'b00, 8'h08, 8'h08, 16'h0008, 1'b0};
        vecs[8] = '{2'b10, 8'h08, 8'h04, 16'h000C, 1'b0};
        vecs[9] = '{2'b11, 8'h04, 8'h08, 16'h000C, 1'b0};

        // Reset held for two edges with a carry-producing add on the inputs.
        applyStimulus(1'b1, 2'b11, 8'hFF, 8'hFF, 2'b11, 2'b11, 2'b11);
        @(negedge clk);
        checkOutput("reset1_w8", got8(), 17'h0_0000);
        checkOutput("reset1_w2", got2(), 17'h0_0000);
        @(negedge clk);
        checkOutput("reset2_w8", got8(), 17'h0_0000);
        checkOutput("reset2_w2", got2(), 17'h0_0000);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("release_w8", got8(), 17'h1_00FE);
        checkOutput("release_w2", got2(), 17'h1_0002);

        // Directed vectors, issued back to back with no idle cycles.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, 2'b00, 2'b00, 2'b00);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), got8(), {vecs[i].expOv, vecs[i].expOut});
        end

        // W=2 hand cases: largest add wraps, carry clears on the next logic op.
        applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 2'b11, 2'b11, 2'b11);
        @(negedge clk);
        checkOutput("w2_add_3_3", got2(), 17'h1_0002);
        applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 2'b10, 2'b11, 2'b01);
        @(negedge clk);
        checkOutput("w2_xor_3_1", got2(), 17'h0_0002);

        // Random traffic on both widths with a single-cycle reset in the middle.
        for (int i = 0; i < 300; i++) begin
            rrst = (i == 150);
            rop8 = 2'($urandom_range(0, 3));
            rop2 = 2'($urandom_range(0, 3));
            ra8  = 8'($urandom_range(0, 255));
            rb8  = 8'($urandom_range(0, 255));
            ra2  = 2'($urandom_range(0, 3));
            rb2  = 2'($urandom_range(0, 3));
            applyStimulus(rrst, rop8, ra8, rb8, rop2, ra2, rb2);
            exp8q = rrst ? 17'h0_0000 : model(8, rop8, ra8, rb8);
            exp2q = rrst ? 17'h0_0000 : model(2, rop2, {6'b0, ra2}, {6'b0, rb2});
            @(negedge clk);
            checkOutput($sformatf("rand%0d_w8", i), got8(), exp8q);
            checkOutput($sformatf("rand%0d_w2", i), got2(), exp2q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
